// File: rtl/icache_sa.sv
// Set-associative instruction cache: combinational lookup, word-by-word line refill,
// per-set round-robin replacement and full flush. Optional hit/miss counters: ICACHE_STATS_EN.
module icache_sa #(
  parameter int unsigned WAYS       = 2,
  parameter int unsigned SETS       = 64,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_req,
  output logic              o_hit,
  output logic [31:0]       o_rdata,
  input  logic              i_flush,
  output logic              o_busy,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_vd,
  input  logic [31:0]       i_mem_data
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]       o_hit_cnt,
  output logic [31:0]       o_miss_cnt
`endif
);

  localparam int unsigned WOFF_W = $clog2(LINE_WORDS);
  localparam int unsigned CNT_W  = (WOFF_W > 0) ? WOFF_W : 1;
  localparam int unsigned OFF_W  = WOFF_W + 2;
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {IDLE, REFILL, FLUSH} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [WAY_W-1:0]  vic_q, vic_d;
  logic [IDX_W-1:0]  fidx_q, fidx_d;
  logic              fpend_q, fpend_d;

  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAY_W-1:0]  rr_q    [SETS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [31:0]       data_q  [SETS][WAYS][LINE_WORDS];

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [CNT_W-1:0]  wsel;
  logic [IDX_W-1:0]  fill_idx;
  logic [TAG_W-1:0]  fill_tag;
  logic [WAY_W-1:0]  hit_way, vic_sel, rr_next;
  logic              hit_any, vic_found, hit;
  logic              wr_word, fill_done, flush_clr, miss_start, flush_start;
  logic              unused_bits;

  assign idx         = i_addr[OFF_W +: IDX_W];
  assign tag         = i_addr[ADDR_W-1 -: TAG_W];
  assign fill_idx    = base_q[OFF_W +: IDX_W];
  assign fill_tag    = base_q[ADDR_W-1 -: TAG_W];
  assign unused_bits = ^i_addr[1:0];

  if (WOFF_W > 0) begin : g_wsel
    assign wsel = i_addr[2 +: CNT_W];
  end else begin : g_wsel_one
    assign wsel = '0;
  end

  // Tag match and victim choice; at most one way can match since a line is only ever filled on a miss.
  always_comb begin
    hit_any   = 1'b0;
    hit_way   = '0;
    vic_found = 1'b0;
    vic_sel   = rr_q[idx];
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[idx][WAY_W'(w)] && (tag_q[idx][w] == tag)) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!vic_found && !valid_q[idx][WAY_W'(w)]) begin
        vic_found = 1'b1;
        vic_sel   = WAY_W'(w);
      end
    end
    hit     = i_req && (state_q == IDLE) && hit_any;
    o_rdata = hit ? data_q[idx][hit_way][wsel] : '0;
  end

  assign o_hit   = hit;
  assign o_busy  = (state_q != IDLE);
  assign rr_next = (rr_q[fill_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[fill_idx] + 1'b1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    base_d      = base_q;
    vic_d       = vic_q;
    fidx_d      = fidx_q;
    fpend_d     = fpend_q;
    o_mem_req   = 1'b0;
    o_mem_addr  = '0;
    wr_word     = 1'b0;
    fill_done   = 1'b0;
    flush_clr   = 1'b0;
    miss_start  = 1'b0;
    flush_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_flush) begin
          state_d     = FLUSH;
          fidx_d      = '0;
          flush_start = 1'b1;
        end else if (i_req && !hit) begin
          state_d    = REFILL;
          base_d     = {i_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          vic_d      = vic_sel;
          cnt_d      = '0;
          miss_start = 1'b1;
        end
      end
      REFILL: begin
        o_mem_req  = 1'b1;
        o_mem_addr = base_q + ADDR_W'({cnt_q, 2'b00});
        if (i_flush) fpend_d = 1'b1;
        if (i_mem_vd) begin
          wr_word = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(LINE_WORDS - 1)) begin
            fill_done = 1'b1;
            cnt_d     = '0;
            if (fpend_q || i_flush) begin
              state_d     = FLUSH;
              fidx_d      = '0;
              fpend_d     = 1'b0;
              flush_start = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      FLUSH: begin
        flush_clr = 1'b1;
        if (fidx_q == IDX_W'(SETS - 1)) state_d = IDLE;
        else                            fidx_d  = fidx_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      vic_q   <= '0;
      fidx_q  <= '0;
      fpend_q <= 1'b0;
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      vic_q   <= vic_d;
      fidx_q  <= fidx_d;
      fpend_q <= fpend_d;
      if (flush_clr) begin
        valid_q[fidx_q] <= '0;
        rr_q[fidx_q]    <= '0;
      end
      if (fill_done) begin
        valid_q[fill_idx][vic_q] <= 1'b1;
        rr_q[fill_idx]           <= rr_next;
      end
    end
  end

  // Tag/data storage is gated by the valid bits, so it needs no reset.
  always_ff @(posedge clk) begin
    if (wr_word)   data_q[fill_idx][vic_q][cnt_q] <= i_mem_data;
    if (fill_done) tag_q[fill_idx][vic_q]         <= fill_tag;
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_hit_cnt  <= '0;
      o_miss_cnt <= '0;
    end else if (flush_start) begin
      o_hit_cnt  <= '0;
      o_miss_cnt <= '0;
    end else begin
      if (hit && (o_hit_cnt != '1))         o_hit_cnt  <= o_hit_cnt + 1'b1;
      if (miss_start && (o_miss_cnt != '1)) o_miss_cnt <= o_miss_cnt + 1'b1;
    end
  end
`endif

endmodule
